eship_wave_scheduler: RTL and testbench
=======================================

# eship_wave_scheduler

Sequencer for the enemy-ship datapath. It owns the per-wave frame counter `ESchedCtr` that drives enemy ship and projectile motion, and walks each wave through entry, formation and clear phases. It arbitrates fire requests among `NM` enemy ships, issuing at most one fire per frame in round-robin order, and only when an enemy projectile slot is free. It sits above the per-ship controllers and drives their `ESchedCtr`/`ESchedFire` inputs.

## Interface
- `NM`, 8, number of enemy ships (fire requesters)
- `NPE`, 4, number of enemy projectile slots
- `ENTRY_LEN`, 256, frames spent in the ENTRY phase (2..1023)
- `FIRE_PERIOD`, 32, minimum frames between fire grants (1..1023)
- `CLEAR_LEN`, 64, frames spent in the CLEAR phase (1..1023)

- `frame_clk`  in  1  sole clock, one edge per video frame
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  begin first wave; sampled only in IDLE
- `EShipAlive`  in  NM  bit i = ship i alive this frame
- `EProjBusy`  in  NPE  bit j = projectile slot j in flight
- `ESchedCtr`  out  10  frames since the current wave entered ENTRY
- `ESchedFire`  out  NM  one-hot or zero; 1-frame fire grant to ship i
- `WaveState`  out  2  0 IDLE, 1 ENTRY, 2 FORMATION, 3 CLEAR
- `WaveNum`  out  4  current wave index
- `WaveClear`  out  1  1-frame pulse on wave cleared

## Operation
- All outputs are registered. Reset (low) clears asynchronously:
  - state IDLE; `ESchedCtr`=0; `ESchedFire`=0; `WaveNum`=0; `WaveClear`=0
  - fire timer = 0; round-robin pointer = NM-1, so ship 0 is granted first.
- IDLE: `ESchedCtr` holds at 0. `Start`=1 moves to ENTRY with ctr=0.
- ENTRY: ctr += 1 per frame. When ctr = ENTRY_LEN-1, the next state is FORMATION and ctr continues to ENTRY_LEN. No fire. `EShipAlive` is ignored, so respawn settling cannot trigger a clear.
- FORMATION: ctr += 1 per frame, saturating at 1023 (no wrap).
  - Fire timer counts 0..FIRE_PERIOD-1 and is reset to 0 on entry to FORMATION.
  - At timer = FIRE_PERIOD-1, a grant is issued if |EShipAlive and not &EProjBusy.
  - The grant goes to the first alive ship strictly after the pointer, modulo NM. The pointer moves to that ship and the timer returns to 0.
  - If the grant is blocked (no slot free or nobody alive), the timer holds at FIRE_PERIOD-1. The grant issues on the first frame the condition is met.
- Clear detection: in FORMATION, `EShipAlive`=0 moves to CLEAR.
  - Same frame: `WaveClear` pulses next frame and `WaveNum` += 1 (wraps 15 to 0).
  - Clear wins over a simultaneous fire: no grant that frame.
- CLEAR: ctr holds its last value. A CLEAR_LEN-frame countdown runs; at expiry the next state is ENTRY with ctr=0. The pointer and timer are kept.
- `Start` is ignored outside IDLE. Nothing returns to IDLE except reset.
- Grant eligibility uses `EShipAlive` of the deciding frame only. A ship killed the same frame is not granted.

## Timing
- One decision per `frame_clk` edge; outputs change one edge after the inputs they depend on.
- `Start` high at edge n gives WaveState=ENTRY, ctr=0 after n. ctr=1 after n+1.
- Entering FORMATION at edge k: timer=0 at k; first eligible grant decision at k+FIRE_PERIOD-1; `ESchedFire` is high for exactly one frame after edge k+FIRE_PERIOD.
- Back-to-back grants are ≥ FIRE_PERIOD frames apart. With FIRE_PERIOD=1, a grant can issue every frame.
- `EProjBusy` freeing at edge m, while a grant is pending, gives a grant visible after edge m.
- Reset asserted mid-wave forces all outputs to reset values immediately, independent of the clock. On release, the block waits in IDLE for `Start`.

## Test plan
Parameters for all scenarios: NM=8, NPE=4, ENTRY_LEN=8, FIRE_PERIOD=4, CLEAR_LEN=4.

- Reset, then Start for 1 frame, all alive, no projectiles busy:
  - ctr 0..7 in ENTRY, WaveState=2 at ctr=8.
  - `ESchedFire` = 0x01, 0x02, 0x04, … every 4 frames, wrapping to 0x01 after 0x80.
- Alive = 0b10010001: grants cycle 0x01, 0x10, 0x80, 0x01.
  - Killing ship 4 on its decision frame yields 0x80 instead of 0x10.
- `EProjBusy`=0xF at the timer expiry:
  - No grant while busy; timer held.
  - Release slot 2: grant appears the next frame, then the next grant follows 4 frames later.
- `EShipAlive` drops to 0 in FORMATION:
  - `WaveClear` pulses once and WaveNum goes 0→1.
  - 4 frames later, ENTRY resumes with ctr=0.
  - No fire during CLEAR.
- 16 consecutive cleared waves: WaveNum wraps 15→0. ctr saturates at 1023 in a long FORMATION.
- Assert Reset in FORMATION while `ESchedFire` is high: all outputs go to 0/IDLE without a clock edge. `Start` is required to restart.

Source files
------------

// File: rtl/eship_wave_scheduler_if.sv
// Control bus between the wave scheduler and the per-ship / projectile datapath.
interface eship_wave_scheduler_if #(
  parameter int NM  = 8,
  parameter int NPE = 4
);
  logic           Start;
  logic [NM-1:0]  EShipAlive;
  logic [NPE-1:0] EProjBusy;
  logic [9:0]     ESchedCtr;
  logic [NM-1:0]  ESchedFire;
  logic [1:0]     WaveState;
  logic [3:0]     WaveNum;
  logic           WaveClear;

  modport master (
    input  Start, EShipAlive, EProjBusy,
    output ESchedCtr, ESchedFire, WaveState, WaveNum, WaveClear
  );

  modport slave (
    output Start, EShipAlive, EProjBusy,
    input  ESchedCtr, ESchedFire, WaveState, WaveNum, WaveClear
  );
endinterface

// File: rtl/eship_wave_scheduler.sv
// Enemy wave sequencer: frame counter, wave phase FSM and round-robin fire
// arbitration among NM ships, gated by projectile slot availability.
module eship_wave_scheduler #(
  parameter int NM          = 8,
  parameter int NPE         = 4,
  parameter int ENTRY_LEN   = 256,
  parameter int FIRE_PERIOD = 32,
  parameter int CLEAR_LEN   = 64
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  eship_wave_scheduler_if.master  bus
);
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ENTRY     = 2'd1,
    FORMATION = 2'd2,
    CLEAR     = 2'd3
  } waveState_t;

  waveState_t     state, stateNxt;
  logic [9:0]     ctr, ctrNxt;
  logic [9:0]     timer, timerNxt;
  logic [9:0]     clrCnt, clrCntNxt;
  logic [NM-1:0]  fire, fireNxt;
  logic [3:0]     waveNum, waveNumNxt;
  logic           waveClear, waveClearNxt;
  logic [PW-1:0]  ptr, ptrNxt;

  logic [NM-1:0]  alive;
  logic [NPE-1:0] busy;
  logic [PW-1:0]  pickHi, pickLo, pick;
  logic           hiVld, loVld;

  assign alive = bus.EShipAlive;
  assign busy  = bus.EProjBusy;

  // Round robin: lowest alive index above ptr, else lowest alive overall.
  always_comb begin
    pickHi = '0;
    pickLo = '0;
    hiVld  = 1'b0;
    loVld  = 1'b0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (alive[i]) begin
        pickLo = PW'(i);
        loVld  = 1'b1;
        if (PW'(i) > ptr) begin
          pickHi = PW'(i);
          hiVld  = 1'b1;
        end
      end
    end
    pick = hiVld ? pickHi : pickLo;
  end

  always_comb begin
    stateNxt     = state;
    ctrNxt       = ctr;
    timerNxt     = timer;
    clrCntNxt    = clrCnt;
    fireNxt      = '0;
    waveNumNxt   = waveNum;
    waveClearNxt = 1'b0;
    ptrNxt       = ptr;
    case (state)
      IDLE: begin
        ctrNxt = '0;
        if (bus.Start) stateNxt = ENTRY;
      end
      ENTRY: begin
        ctrNxt = ctr + 10'd1;
        if (ctr == 10'(ENTRY_LEN - 1)) begin
          stateNxt = FORMATION;
          timerNxt = '0;
        end
      end
      FORMATION: begin
        ctrNxt = (ctr == 10'h3FF) ? ctr : ctr + 10'd1;
        // A wiped-out formation takes priority over any pending fire.
        if (alive == '0) begin
          stateNxt     = CLEAR;
          waveClearNxt = 1'b1;
          waveNumNxt   = waveNum + 4'd1;
          clrCntNxt    = 10'(CLEAR_LEN - 1);
        end else if (timer == 10'(FIRE_PERIOD - 1)) begin
          // Blocked grants leave the timer parked at expiry.
          if (loVld && !(&busy)) begin
            fireNxt[pick] = 1'b1;
            ptrNxt        = pick;
            timerNxt      = '0;
          end
        end else begin
          timerNxt = timer + 10'd1;
        end
      end
      CLEAR: begin
        if (clrCnt == '0) begin
          stateNxt = ENTRY;
          ctrNxt   = '0;
        end else begin
          clrCntNxt = clrCnt - 10'd1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ctr       <= '0;
      timer     <= '0;
      clrCnt    <= '0;
      fire      <= '0;
      waveNum   <= '0;
      waveClear <= 1'b0;
      ptr       <= PW'(NM - 1);
    end else begin
      state     <= stateNxt;
      ctr       <= ctrNxt;
      timer     <= timerNxt;
      clrCnt    <= clrCntNxt;
      fire      <= fireNxt;
      waveNum   <= waveNumNxt;
      waveClear <= waveClearNxt;
      ptr       <= ptrNxt;
    end
  end

  assign bus.ESchedCtr  = ctr;
  assign bus.ESchedFire = fire;
  assign bus.WaveState  = state;
  assign bus.WaveNum    = waveNum;
  assign bus.WaveClear  = waveClear;
endmodule

// File: tb/tb_eship_wave_scheduler.sv
// Directed bench for eship_wave_scheduler with NM=8, NPE=4, ENTRY_LEN=8,
// FIRE_PERIOD=4, CLEAR_LEN=4.
module tb_eship_wave_scheduler;
  logic frame_clk;
  logic Reset;
  int   checks;
  int   failures;

  eship_wave_scheduler_if #(.NM(8), .NPE(4)) bus();

  eship_wave_scheduler #(
    .NM(8), .NPE(4), .ENTRY_LEN(8), .FIRE_PERIOD(4), .CLEAR_LEN(4)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Reset, start a wave and step to the first FORMATION frame (timer=0).
  task automatic enterFormation();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.Start = 1'b0;
    bus.EShipAlive = 8'hFF;
    bus.EProjBusy = 4'h0;
    #1;
    checks++;
    if (bus.WaveState !== 2'd0 || bus.ESchedCtr !== 10'd0 || bus.ESchedFire !== 8'h00 ||
        bus.WaveNum !== 4'd0 || bus.WaveClear !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got st=%0d ctr=%0d fire=%h wn=%0d wc=%b exp all zero",
               bus.WaveState, bus.ESchedCtr, bus.ESchedFire, bus.WaveNum, bus.WaveClear);
    end
    tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (bus.WaveState !== 2'd0 || bus.ESchedCtr !== 10'd0) begin
      failures++;
      $display("FAIL idle_wait got st=%0d ctr=%0d exp st=0 ctr=0", bus.WaveState, bus.ESchedCtr);
    end
  endtask

  task automatic test_entry_and_rr();
    logic [7:0] exp;
    bus.EShipAlive = 8'hFF;
    bus.EProjBusy = 4'h0;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    checks++;
    if (bus.WaveState !== 2'd1 || bus.ESchedCtr !== 10'd0) begin
      failures++;
      $display("FAIL start_entry got st=%0d ctr=%0d exp st=1 ctr=0", bus.WaveState, bus.ESchedCtr);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (bus.WaveState !== 2'd1 || bus.ESchedCtr !== 10'(i) || bus.ESchedFire !== 8'h00) begin
        failures++;
        $display("FAIL entry_ctr got st=%0d ctr=%0d fire=%h exp st=1 ctr=%0d fire=00",
                 bus.WaveState, bus.ESchedCtr, bus.ESchedFire, i);
      end
    end
    tick();
    checks++;
    if (bus.WaveState !== 2'd2 || bus.ESchedCtr !== 10'd8) begin
      failures++;
      $display("FAIL to_formation got st=%0d ctr=%0d exp st=2 ctr=8", bus.WaveState, bus.ESchedCtr);
    end
    for (int g = 0; g < 10; g++) begin
      repeat (3) begin
        tick();
        checks++;
        if (bus.ESchedFire !== 8'h00) begin
          failures++;
          $display("FAIL rr_gap got fire=%h exp 00", bus.ESchedFire);
        end
      end
      tick();
      exp = 8'h01 << (g % 8);
      checks++;
      if (bus.ESchedFire !== exp) begin
        failures++;
        $display("FAIL rr_grant got fire=%h exp %h", bus.ESchedFire, exp);
      end
    end
  endtask

  task automatic test_sparse();
    logic [7:0] seq [4];
    seq[0] = 8'h01; seq[1] = 8'h10; seq[2] = 8'h80; seq[3] = 8'h01;
    bus.EShipAlive = 8'h91;
    bus.EProjBusy = 4'h0;
    enterFormation();
    for (int g = 0; g < 4; g++) begin
      repeat (3) tick();
      tick();
      checks++;
      if (bus.ESchedFire !== seq[g]) begin
        failures++;
        $display("FAIL sparse_grant got fire=%h exp %h", bus.ESchedFire, seq[g]);
      end
    end
    // Ship 4 would be next; it dies on the deciding frame.
    repeat (3) tick();
    bus.EShipAlive = 8'h81;
    tick();
    bus.EShipAlive = 8'h91;
    checks++;
    if (bus.ESchedFire !== 8'h80) begin
      failures++;
      $display("FAIL kill_on_decision got fire=%h exp 80", bus.ESchedFire);
    end
  endtask

  task automatic test_busy();
    bus.EShipAlive = 8'hFF;
    bus.EProjBusy = 4'hF;
    enterFormation();
    repeat (10) begin
      tick();
      checks++;
      if (bus.ESchedFire !== 8'h00) begin
        failures++;
        $display("FAIL busy_block got fire=%h exp 00", bus.ESchedFire);
      end
    end
    bus.EProjBusy = 4'hB;
    tick();
    checks++;
    if (bus.ESchedFire !== 8'h01) begin
      failures++;
      $display("FAIL busy_release got fire=%h exp 01", bus.ESchedFire);
    end
    repeat (3) begin
      tick();
      checks++;
      if (bus.ESchedFire !== 8'h00) begin
        failures++;
        $display("FAIL busy_gap got fire=%h exp 00", bus.ESchedFire);
      end
    end
    tick();
    checks++;
    if (bus.ESchedFire !== 8'h02) begin
      failures++;
      $display("FAIL busy_next got fire=%h exp 02", bus.ESchedFire);
    end
  endtask

  task automatic test_clear();
    bus.EShipAlive = 8'hFF;
    bus.EProjBusy = 4'h0;
    enterFormation();
    repeat (2) tick();
    bus.EShipAlive = 8'h00;
    tick();
    checks++;
    if (bus.WaveState !== 2'd3 || bus.WaveClear !== 1'b1 || bus.WaveNum !== 4'd1 ||
        bus.ESchedFire !== 8'h00) begin
      failures++;
      $display("FAIL clear_enter got st=%0d wc=%b wn=%0d fire=%h exp st=3 wc=1 wn=1 fire=00",
               bus.WaveState, bus.WaveClear, bus.WaveNum, bus.ESchedFire);
    end
    bus.Start = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (bus.WaveState !== 2'd3 || bus.WaveClear !== 1'b0 || bus.ESchedFire !== 8'h00) begin
        failures++;
        $display("FAIL clear_hold got st=%0d wc=%b fire=%h exp st=3 wc=0 fire=00",
                 bus.WaveState, bus.WaveClear, bus.ESchedFire);
      end
    end
    bus.Start = 1'b0;
    tick();
    checks++;
    if (bus.WaveState !== 2'd1 || bus.ESchedCtr !== 10'd0 || bus.WaveNum !== 4'd1) begin
      failures++;
      $display("FAIL clear_exit got st=%0d ctr=%0d wn=%0d exp st=1 ctr=0 wn=1",
               bus.WaveState, bus.ESchedCtr, bus.WaveNum);
    end
  endtask

  // Continues from ENTRY with WaveNum=1; zero alive is ignored during ENTRY.
  task automatic test_wave_wrap();
    bus.EShipAlive = 8'h00;
    for (int w = 2; w <= 16; w++) begin
      repeat (8) tick();
      checks++;
      if (bus.WaveState !== 2'd2) begin
        failures++;
        $display("FAIL wrap_formation got st=%0d exp 2", bus.WaveState);
      end
      tick();
      checks++;
      if (bus.WaveState !== 2'd3 || bus.WaveClear !== 1'b1 || bus.WaveNum !== 4'(w % 16)) begin
        failures++;
        $display("FAIL wrap_clear got st=%0d wc=%b wn=%0d exp st=3 wc=1 wn=%0d",
                 bus.WaveState, bus.WaveClear, bus.WaveNum, w % 16);
      end
      repeat (4) tick();
    end
    bus.EShipAlive = 8'hFF;
  endtask

  task automatic test_saturate();
    bus.EShipAlive = 8'hFF;
    bus.EProjBusy = 4'hF;
    enterFormation();
    repeat (1015) tick();
    checks++;
    if (bus.ESchedCtr !== 10'd1023 || bus.WaveState !== 2'd2) begin
      failures++;
      $display("FAIL ctr_reach got ctr=%0d st=%0d exp ctr=1023 st=2", bus.ESchedCtr, bus.WaveState);
    end
    repeat (3) tick();
    checks++;
    if (bus.ESchedCtr !== 10'd1023) begin
      failures++;
      $display("FAIL ctr_saturate got ctr=%0d exp 1023", bus.ESchedCtr);
    end
    bus.EProjBusy = 4'h0;
    tick();
    checks++;
    if (bus.ESchedFire !== 8'h01) begin
      failures++;
      $display("FAIL sat_grant got fire=%h exp 01", bus.ESchedFire);
    end
  endtask

  task automatic test_async_reset();
    bus.EShipAlive = 8'hFF;
    bus.EProjBusy = 4'h0;
    enterFormation();
    repeat (4) tick();
    checks++;
    if (bus.ESchedFire !== 8'h01) begin
      failures++;
      $display("FAIL pre_reset_fire got fire=%h exp 01", bus.ESchedFire);
    end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.WaveState !== 2'd0 || bus.ESchedCtr !== 10'd0 || bus.ESchedFire !== 8'h00 ||
        bus.WaveNum !== 4'd0 || bus.WaveClear !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got st=%0d ctr=%0d fire=%h wn=%0d wc=%b exp all zero",
               bus.WaveState, bus.ESchedCtr, bus.ESchedFire, bus.WaveNum, bus.WaveClear);
    end
    tick();
    Reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.WaveState !== 2'd0 || bus.ESchedCtr !== 10'd0) begin
      failures++;
      $display("FAIL wait_start got st=%0d ctr=%0d exp st=0 ctr=0", bus.WaveState, bus.ESchedCtr);
    end
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    checks++;
    if (bus.WaveState !== 2'd1 || bus.ESchedCtr !== 10'd0) begin
      failures++;
      $display("FAIL restart got st=%0d ctr=%0d exp st=1 ctr=0", bus.WaveState, bus.ESchedCtr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_entry_and_rr();
    test_sparse();
    test_busy();
    test_clear();
    test_wave_wrap();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
